// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle for rv32i_mem_arbiter: fetch port, load/store port, external
// memory port and the busy flag.
//   slave  : arbiter side (takes requests, drives memory, returns acks)
//   master : environment side (requesters and memory model)
interface rv32i_mem_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_err;
  // load/store port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_width;
  logic        d_unsigned;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  // external memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // status
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_width, d_unsigned, d_wdata,
           mem_rdata, mem_ack,
    output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_width, d_unsigned, d_wdata,
           mem_rdata, mem_ack,
    input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one external memory port between instruction fetch and load/store.
// One transaction at a time; arbitration happens only in IDLE. Generates byte
// enables and lane-replicated store data, aligns and extends load data, and
// reports misaligned accesses and memory timeouts as errors.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : rv32i_mem_arbiter_if.slave (fetch, data, memory ports, busy)
// Parameters:
//   DATA_PRIORITY  : 1 = data wins ties, 0 = round-robin on last grant
//   TIMEOUT_CYCLES : memory wait cycles before a bus error (1..255)
module rv32i_mem_arbiter #(
  parameter bit          DATA_PRIORITY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  rv32i_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DATA, S_ERR, S_RESP} state_e;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        gnt_data_q, gnt_data_d;    // 1 = current transaction is data
  logic        last_data_q, last_data_d;  // 1 = last grant went to data
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [1:0]  width_q, width_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        pick_data;
  logic        misaligned;
  logic [7:0]  cnt_inc;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Load alignment: move the addressed byte/halfword to bit 0, then extend.
  always_comb begin
    shifted   = bus.mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (width_q)
      2'd0:    load_data = uns_q ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = uns_q ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    gnt_data_d  = gnt_data_q;
    last_data_d = last_data_q;
    err_d       = err_q;
    we_d        = we_q;
    uns_d       = uns_q;
    width_d     = width_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    pick_data   = 1'b0;
    misaligned  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          pick_data   = bus.d_req &&
                        (!bus.if_req || DATA_PRIORITY || !last_data_q);
          gnt_data_d  = pick_data;
          last_data_d = pick_data;
          cnt_d       = '0;
          err_d       = 1'b0;
          if (pick_data) begin
            misaligned = (bus.d_width == 2'd3) ||
                         (bus.d_width == 2'd1 && bus.d_addr[0]) ||
                         (bus.d_width == 2'd2 && bus.d_addr[1:0] != 2'b00);
            we_d    = bus.d_we;
            uns_d   = bus.d_unsigned;
            width_d = bus.d_width;
            off_d   = bus.d_addr[1:0];
          end else begin
            misaligned = (bus.if_addr[1:0] != 2'b00);
            we_d    = 1'b0;
            uns_d   = 1'b0;
            width_d = 2'd2;
            off_d   = bus.if_addr[1:0];
          end
          if (misaligned) begin
            state_d = S_ERR;
          end else begin
            state_d   = pick_data ? S_DATA : S_FETCH;
            mem_req_d = 1'b1;
            if (pick_data) begin
              mem_addr_d = {bus.d_addr[31:2], 2'b00};
              mem_we_d   = bus.d_we;
              case (bus.d_width)
                2'd0: begin
                  mem_be_d    = 4'b0001 << bus.d_addr[1:0];
                  mem_wdata_d = {4{bus.d_wdata[7:0]}};
                end
                2'd1: begin
                  mem_be_d    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                  mem_wdata_d = {2{bus.d_wdata[15:0]}};
                end
                default: begin
                  mem_be_d    = 4'b1111;
                  mem_wdata_d = bus.d_wdata;
                end
              endcase
            end else begin
              mem_addr_d  = {bus.if_addr[31:2], 2'b00};
              mem_we_d    = 1'b0;
              mem_be_d    = 4'b1111;
              mem_wdata_d = '0;
            end
          end
        end
      end

      S_FETCH, S_DATA: begin
        // A mem_ack arriving on the expiry cycle still completes normally.
        if (bus.mem_ack) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b0;
          if (gnt_data_q) d_rdata_d  = we_q ? '0 : load_data;
          else            if_rdata_d = bus.mem_rdata;
        end else if (cnt_inc == TO_LIMIT) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (gnt_data_q) d_rdata_d  = '0;
          else            if_rdata_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_ERR: begin
        state_d = S_RESP;
        err_d   = 1'b1;
        if (gnt_data_q) d_rdata_d  = '0;
        else            if_rdata_d = '0;
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gnt_data_q  <= 1'b0;
      last_data_q <= 1'b1;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      width_q     <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_data_q  <= gnt_data_d;
      last_data_q <= last_data_d;
      err_q       <= err_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      width_q     <= width_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = (state_q == S_RESP) && !gnt_data_q;
  assign bus.d_ack     = (state_q == S_RESP) &&  gnt_data_q;
  assign bus.if_err    = (state_q == S_RESP) && !gnt_data_q && err_q;
  assign bus.d_err     = (state_q == S_RESP) &&  gnt_data_q && err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter. u_dut_p: data priority, 4-cycle
// timeout. u_dut_r: round-robin, used for the contention sequence.
module tb_rv32i_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // shared stimulus; requests are per instance
  logic        if_req_p, d_req_p, if_req_r, d_req_r;
  logic [31:0] if_addr;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_width;
  logic        d_unsigned;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  rv32i_mem_arbiter_if bus_p ();
  rv32i_mem_arbiter_if bus_r ();

  assign bus_p.if_req     = if_req_p;
  assign bus_p.d_req      = d_req_p;
  assign bus_p.if_addr    = if_addr;
  assign bus_p.d_we       = d_we;
  assign bus_p.d_addr     = d_addr;
  assign bus_p.d_width    = d_width;
  assign bus_p.d_unsigned = d_unsigned;
  assign bus_p.d_wdata    = d_wdata;
  assign bus_p.mem_rdata  = mem_rdata;
  assign bus_p.mem_ack    = mem_ack;

  assign bus_r.if_req     = if_req_r;
  assign bus_r.d_req      = d_req_r;
  assign bus_r.if_addr    = if_addr;
  assign bus_r.d_we       = d_we;
  assign bus_r.d_addr     = d_addr;
  assign bus_r.d_width    = d_width;
  assign bus_r.d_unsigned = d_unsigned;
  assign bus_r.d_wdata    = d_wdata;
  assign bus_r.mem_rdata  = mem_rdata;
  assign bus_r.mem_ack    = mem_ack;

  rv32i_mem_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT_CYCLES(4)) u_dut_p (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_p)
  );

  rv32i_mem_arbiter #(.DATA_PRIORITY(1'b0), .TIMEOUT_CYCLES(255)) u_dut_r (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_r)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic data_xfer(input string tag, input logic we,
                           input logic [31:0] addr, input logic [1:0] width,
                           input logic uns, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int unsigned waits,
                           input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata);
    d_we = we; d_addr = addr; d_width = width; d_unsigned = uns;
    d_wdata = wdata; d_req_p = 1'b1;
    tick();
    check({tag, ":mem_req"}, 32'(bus_p.mem_req), 32'd1);
    check({tag, ":mem_addr"}, bus_p.mem_addr, {addr[31:2], 2'b00});
    check({tag, ":mem_we"}, 32'(bus_p.mem_we), 32'(we));
    check({tag, ":mem_be"}, 32'(bus_p.mem_be), 32'(exp_be));
    if (we) check({tag, ":mem_wdata"}, bus_p.mem_wdata, exp_wdata);
    for (int unsigned i = 0; i < waits; i++) begin
      tick();
      check({tag, ":wait"}, 32'({bus_p.mem_req, bus_p.d_ack}), 32'd2);
    end
    mem_rdata = rdata; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, ":d_ack"}, 32'(bus_p.d_ack), 32'd1);
    check({tag, ":d_err"}, 32'(bus_p.d_err), 32'd0);
    check({tag, ":d_rdata"}, bus_p.d_rdata, exp_rdata);
    check({tag, ":req_drop"}, 32'({bus_p.mem_req, bus_p.if_ack}), 32'd0);
    d_req_p = 1'b0;
    tick();
    check({tag, ":idle"}, 32'({bus_p.busy, bus_p.d_ack}), 32'd0);
  endtask

  task automatic fetch_xfer(input string tag, input logic [31:0] addr,
                            input logic [31:0] rdata, input int unsigned waits);
    if_addr = addr; if_req_p = 1'b1;
    tick();
    check({tag, ":mem_req"}, 32'(bus_p.mem_req), 32'd1);
    check({tag, ":mem_addr"}, bus_p.mem_addr, addr);
    check({tag, ":be_we"}, 32'({bus_p.mem_be, bus_p.mem_we}), 32'h1E);
    for (int unsigned i = 0; i < waits; i++) tick();
    mem_rdata = rdata; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, ":if_ack_err"}, 32'({bus_p.if_ack, bus_p.if_err, bus_p.d_ack}),
          32'd4);
    check({tag, ":if_rdata"}, bus_p.if_rdata, rdata);
    if_req_p = 1'b0;
    tick();
    check({tag, ":idle"}, 32'(bus_p.busy), 32'd0);
  endtask

  task automatic err_xfer(input string tag, input logic is_fetch,
                          input logic [31:0] addr, input logic [1:0] width);
    if (is_fetch) begin
      if_addr = addr; if_req_p = 1'b1;
    end else begin
      d_we = 1'b0; d_addr = addr; d_width = width; d_unsigned = 1'b0;
      d_req_p = 1'b1;
    end
    tick();
    check({tag, ":err_state"},
          32'({bus_p.busy, bus_p.mem_req, bus_p.if_ack, bus_p.d_ack}), 32'h8);
    tick();
    check({tag, ":mem_req"}, 32'(bus_p.mem_req), 32'd0);
    if (is_fetch) begin
      check({tag, ":ack_err"}, 32'({bus_p.if_ack, bus_p.if_err, bus_p.d_ack}),
            32'd6);
      check({tag, ":rdata"}, bus_p.if_rdata, 32'd0);
    end else begin
      check({tag, ":ack_err"}, 32'({bus_p.d_ack, bus_p.d_err, bus_p.if_ack}),
            32'd6);
      check({tag, ":rdata"}, bus_p.d_rdata, 32'd0);
    end
    if_req_p = 1'b0; d_req_p = 1'b0;
    tick();
    check({tag, ":idle"}, 32'(bus_p.busy), 32'd0);
  endtask

  initial begin
    int unsigned req_cycles;
    int unsigned n_p, n_r, overlap;
    int unsigned fl_p, dl_p, fl_r, dl_r;
    logic [3:0]  ord_p, ord_r;

    reset = 1'b1;
    if_req_p = 1'b0; d_req_p = 1'b0; if_req_r = 1'b0; d_req_r = 1'b0;
    if_addr = '0; d_we = 1'b0; d_addr = '0; d_width = '0; d_unsigned = 1'b0;
    d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset:outs", 32'({bus_p.mem_req, bus_p.mem_we, bus_p.mem_be,
          bus_p.if_ack, bus_p.if_err, bus_p.d_ack, bus_p.d_err, bus_p.busy}),
          32'd0);
    check("reset:rdata", bus_p.if_rdata | bus_p.d_rdata | bus_p.mem_addr, 32'd0);

    data_xfer("lb",  1'b0, 32'h1003, 2'd0, 1'b0, '0, 32'h80FF_FFFF, 0,
              4'b1000, '0, 32'hFFFF_FF80);
    data_xfer("lbu", 1'b0, 32'h1003, 2'd0, 1'b1, '0, 32'h80FF_FFFF, 0,
              4'b1000, '0, 32'h0000_0080);
    data_xfer("lh",  1'b0, 32'h1002, 2'd1, 1'b0, '0, 32'h8001_1234, 1,
              4'b1100, '0, 32'hFFFF_8001);
    data_xfer("sh",  1'b1, 32'h2002, 2'd1, 1'b0, 32'h0000_BEEF, '0, 3,
              4'b1100, 32'hBEEF_BEEF, 32'd0);
    data_xfer("sb",  1'b1, 32'h2001, 2'd0, 1'b0, 32'h1234_56A5, '0, 0,
              4'b0010, 32'hA5A5_A5A5, 32'd0);
    fetch_xfer("fetch", 32'h0000_0100, 32'h0050_0093, 0);

    err_xfer("mis_word", 1'b0, 32'h2001, 2'd2);
    err_xfer("mis_w3",   1'b0, 32'h2000, 2'd3);
    err_xfer("mis_fetch", 1'b1, 32'h0000_0102, 2'd0);

    // timeout: no mem_ack, then mem_ack on the 4th request cycle
    for (int pass = 0; pass < 2; pass++) begin
      if_addr = 32'h200; if_req_p = 1'b1; mem_rdata = 32'h0000_0013;
      req_cycles = 0;
      tick();
      for (int c = 0; c < 12 && !bus_p.if_ack; c++) begin
        if (bus_p.mem_req) req_cycles++;
        mem_ack = (pass == 1 && req_cycles == 4);
        tick();
        mem_ack = 1'b0;
      end
      if (pass == 0) begin
        check("tmo:req_cycles", req_cycles, 32'd4);
        check("tmo:ack_err", 32'({bus_p.if_ack, bus_p.if_err}), 32'd3);
        check("tmo:rdata", bus_p.if_rdata, 32'd0);
      end else begin
        check("tmo_ack:req_cycles", req_cycles, 32'd4);
        check("tmo_ack:ack_err", 32'({bus_p.if_ack, bus_p.if_err}), 32'd2);
        check("tmo_ack:rdata", bus_p.if_rdata, 32'h0000_0013);
      end
      if_req_p = 1'b0;
      tick();
    end

    // reset while a load is outstanding; mem_ack during reset is ignored
    d_we = 1'b0; d_addr = 32'h4000; d_width = 2'd2; d_unsigned = 1'b0;
    d_req_p = 1'b1;
    tick();
    check("rst_mid:mem_req", 32'(bus_p.mem_req), 32'd1);
    reset = 1'b1; d_req_p = 1'b0;
    tick();
    check("rst_mid:req_low", 32'(bus_p.mem_req), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; reset = 1'b0;
    tick();
    check("rst_mid:outs", 32'({bus_p.mem_req, bus_p.mem_be, bus_p.if_ack,
          bus_p.d_ack, bus_p.d_err, bus_p.busy}), 32'd0);
    check("rst_mid:rdata", bus_p.d_rdata | bus_p.if_rdata, 32'd0);
    fetch_xfer("post_rst", 32'h0000_0300, 32'h0000_0013, 1);

    // contention: both requesters want two transactions each
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if_addr = 32'h100; d_addr = 32'h3000; d_width = 2'd2; d_we = 1'b0;
    fl_p = 2; dl_p = 2; fl_r = 2; dl_r = 2;
    if_req_p = 1'b1; d_req_p = 1'b1; if_req_r = 1'b1; d_req_r = 1'b1;
    n_p = 0; n_r = 0; overlap = 0; ord_p = '0; ord_r = '0;
    for (int c = 0; c < 40 && (n_p < 4 || n_r < 4); c++) begin
      tick();
      mem_ack = bus_p.mem_req | bus_r.mem_req;
      if ((bus_p.if_ack && bus_p.d_ack) || (bus_r.if_ack && bus_r.d_ack))
        overlap++;
      if (bus_p.if_ack || bus_p.d_ack) begin
        ord_p = {ord_p[2:0], bus_p.d_ack};
        n_p++;
        if (bus_p.if_ack && --fl_p == 0) if_req_p = 1'b0;
        if (bus_p.d_ack  && --dl_p == 0) d_req_p  = 1'b0;
      end
      if (bus_r.if_ack || bus_r.d_ack) begin
        ord_r = {ord_r[2:0], bus_r.d_ack};
        n_r++;
        if (bus_r.if_ack && --fl_r == 0) if_req_r = 1'b0;
        if (bus_r.d_ack  && --dl_r == 0) d_req_r  = 1'b0;
      end
    end
    mem_ack = 1'b0;
    check("prio:count", n_p, 32'd4);
    check("prio:order", 32'(ord_p), 32'b1100);
    check("rr:count", n_r, 32'd4);
    check("rr:order", 32'(ord_r), 32'b0101);
    check("ack_overlap", overlap, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
